// File: rtl/filter_accumulator_pkg.sv
// Shared FIR filter constants: accumulator geometry, output scaling and the
// one-hot state encoding of the stereo accumulator back end.
package filter_accumulator_pkg;

  localparam int TAPS   = 512;
  localparam int PROD_W = 32;
  localparam int ACC_W  = PROD_W + $clog2(TAPS);
  localparam int SHIFT  = 15;
  localparam int OUT_W  = 16;

  localparam int ST_IDLE_IDX    = 0;
  localparam int ST_ACCUM_IDX   = 1;
  localparam int ST_PRESENT_IDX = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_ACCUM   = 3'b010,
    ST_PRESENT = 3'b100
  } acc_state_e;

  function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/filter_accumulator_if.sv
// Product/strobe inputs and rts/rtr stereo sample output of the accumulator.
interface filter_accumulator_if;
  import filter_accumulator_pkg::*;

  logic                  accumulator_load;
  logic                  accumulator_enable;
  logic [PROD_W-1:0]     accumulator_in_left;
  logic [PROD_W-1:0]     accumulator_in_right;
  logic [2*OUT_W-1:0]    acc_aud_out;
  logic                  acc_aud_out_rts;
  logic                  acc_aud_out_rtr;
  logic [1:0]            acc_clip;
  logic                  acc_overrun;

  modport master (
    output accumulator_load, accumulator_enable,
    output accumulator_in_left, accumulator_in_right,
    output acc_aud_out_rtr,
    input  acc_aud_out, acc_aud_out_rts, acc_clip, acc_overrun
  );

  modport slave (
    input  accumulator_load, accumulator_enable,
    input  accumulator_in_left, accumulator_in_right,
    input  acc_aud_out_rtr,
    output acc_aud_out, acc_aud_out_rts, acc_clip, acc_overrun
  );

endinterface

// File: rtl/filter_round_sat.sv
// Round-half-up, arithmetic shift by SHIFT and saturate one channel sum to 16 bits.
module filter_round_sat
  import filter_accumulator_pkg::*;
(
  input  logic [ACC_W-1:0] acc_i,
  output logic [OUT_W-1:0] sample_o,
  output logic             clip_o
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] RND_BIAS =
    {{(SUM_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};

  logic [SUM_W-1:0]       sum_s;
  logic [SUM_W-1:0]       shr_s;
  logic [SUM_W-OUT_W:0]   upper_s;
  logic                   fits_s;

  // One guard bit keeps the rounding add from wrapping near full scale.
  assign sum_s   = {acc_i[ACC_W-1], acc_i} + RND_BIAS;
  assign shr_s   = $signed(sum_s) >>> SHIFT;
  assign upper_s = shr_s[SUM_W-1:OUT_W-1];
  assign fits_s  = (&upper_s) | ~(|upper_s);

  // Clamp towards the sign of the shifted sum when it leaves the 16-bit range.
  always_comb begin
    sample_o = shr_s[OUT_W-1:0];
    clip_o   = 1'b0;
    if (!fits_s) begin
      clip_o   = 1'b1;
      sample_o = shr_s[SUM_W-1] ? 16'h8000 : 16'h7FFF;
    end else begin
      sample_o = shr_s[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/filter_accumulator.sv
// Stereo MAC back end: sums a tap sweep per channel, finalizes on the falling
// edge of enable and holds the packed sample in a single rts/rtr output slot.
module filter_accumulator
  import filter_accumulator_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstb,
  filter_accumulator_if.slave  bus
);

  logic [ACC_W-1:0]     acc_l_q, acc_l_d;
  logic [ACC_W-1:0]     acc_r_q, acc_r_d;
  logic                 en_prev_q;
  acc_state_e           state_q, state_d;
  logic [2*OUT_W-1:0]   aud_q, aud_d;
  logic                 rts_q, rts_d;
  logic [1:0]           clip_q, clip_d;
  logic                 ovr_q, ovr_d;

  logic [OUT_W-1:0]     smp_l_s, smp_r_s;
  logic                 clip_l_s, clip_r_s;
  logic                 done_s;
  logic                 xfer_s;
  logic                 slot_free_s;

  assign done_s      = en_prev_q & ~bus.accumulator_enable;
  assign xfer_s      = rts_q & bus.acc_aud_out_rtr;
  assign slot_free_s = ~rts_q | bus.acc_aud_out_rtr;

  filter_round_sat u_rs_left (
    .acc_i    (acc_l_q),
    .sample_o (smp_l_s),
    .clip_o   (clip_l_s)
  );

  filter_round_sat u_rs_right (
    .acc_i    (acc_r_q),
    .sample_o (smp_r_s),
    .clip_o   (clip_r_s)
  );

  // Accumulator next state; load restarts the sum, sums wrap at ACC_W bits.
  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (bus.accumulator_enable) begin
      if (bus.accumulator_load) begin
        acc_l_d = sext_prod(bus.accumulator_in_left);
        acc_r_d = sext_prod(bus.accumulator_in_right);
      end else begin
        acc_l_d = acc_l_q + sext_prod(bus.accumulator_in_left);
        acc_r_d = acc_r_q + sext_prod(bus.accumulator_in_right);
      end
    end else begin
      acc_l_d = acc_l_q;
      acc_r_d = acc_r_q;
    end
  end

  // Sweep sequencing; presentation and the next sweep may overlap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.accumulator_enable) state_d = ST_ACCUM;
        else                        state_d = ST_IDLE;
      end
      ST_ACCUM: begin
        if (bus.accumulator_enable) state_d = ST_ACCUM;
        else if (slot_free_s)       state_d = ST_PRESENT;
        else                        state_d = ST_IDLE;
      end
      ST_PRESENT: begin
        if (bus.accumulator_enable) state_d = ST_ACCUM;
        else if (xfer_s)            state_d = ST_IDLE;
        else                        state_d = ST_PRESENT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot: a transfer on the done edge frees the slot for the new result.
  always_comb begin
    aud_d  = aud_q;
    clip_d = clip_q;
    rts_d  = rts_q;
    ovr_d  = ovr_q;
    if (done_s) begin
      if (slot_free_s) begin
        aud_d  = {smp_l_s, smp_r_s};
        clip_d = {clip_l_s, clip_r_s};
        rts_d  = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (xfer_s) begin
      rts_d = 1'b0;
    end else begin
      rts_d = rts_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      en_prev_q <= 1'b0;
      state_q   <= ST_IDLE;
      aud_q     <= '0;
      rts_q     <= 1'b0;
      clip_q    <= 2'b00;
      ovr_q     <= 1'b0;
    end else begin
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      en_prev_q <= bus.accumulator_enable;
      state_q   <= state_d;
      aud_q     <= aud_d;
      rts_q     <= rts_d;
      clip_q    <= clip_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.acc_aud_out     = aud_q;
  assign bus.acc_aud_out_rts = rts_q;
  assign bus.acc_clip        = clip_q;
  assign bus.acc_overrun     = ovr_q;

endmodule

// File: tb/tb_filter_accumulator.sv
// Scoreboard bench for filter_accumulator: directed scenarios plus random sweeps
// checked against an arithmetic reference model of sums, rounding and the slot.
module tb_filter_accumulator;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  clip;
  } exp_t;

  logic clk  = 1'b0;
  logic rstb = 1'b0;

  filter_accumulator_if bus ();

  filter_accumulator dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];

  longint m_acc_l, m_acc_r;
  bit     m_en_d, m_full, m_ovr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint wrap41(input longint v);
    return {{23{v[40]}}, v[40:0]};
  endfunction

  function automatic logic [16:0] fin(input longint a);
    longint r;
    r = (a + 64'sd16384) >>> 15;
    if (r > 64'sd32767)       return {1'b1, 16'h7FFF};
    else if (r < -64'sd32768) return {1'b1, 16'h8000};
    else                      return {1'b0, r[15:0]};
  endfunction

  function automatic exp_t mk_exp(input longint l, input longint r);
    logic [16:0] lo, ro;
    exp_t e;
    lo = fin(l);
    ro = fin(r);
    e.data = {lo[15:0], ro[15:0]};
    e.clip = {lo[16], ro[16]};
    return e;
  endfunction

  function automatic logic [31:0] rnd_prod();
    logic [31:0] v;
    int sh;
    v  = $urandom;
    sh = $urandom_range(0, 24);
    return $signed(v) >>> sh;
  endfunction

  task automatic model_reset();
    m_acc_l = 0;
    m_acc_r = 0;
    m_en_d  = 1'b0;
    m_full  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // One clock: drive inputs, advance the reference model, then check rts/overrun.
  task automatic cyc(input bit en, input bit ld, input logic [31:0] l,
                     input logic [31:0] r, input bit rdy);
    longint sl, sr;
    bus.accumulator_enable   = en;
    bus.accumulator_load     = ld;
    bus.accumulator_in_left  = l;
    bus.accumulator_in_right = r;
    bus.acc_aud_out_rtr      = rdy;
    if (m_en_d && !en) begin
      if (!m_full || rdy) begin
        sb_q.push_back(mk_exp(m_acc_l, m_acc_r));
        m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    if (en) begin
      sl = $signed(l);
      sr = $signed(r);
      m_acc_l = wrap41(ld ? sl : m_acc_l + sl);
      m_acc_r = wrap41(ld ? sr : m_acc_r + sr);
    end
    m_en_d = en;
    @(posedge clk);
    #1;
    chk("rts", bus.acc_aud_out_rts, m_full);
    chk("overrun", bus.acc_overrun, m_ovr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic check_out(input string name, input logic [31:0] d, input logic [1:0] c);
    chk({name, "_data"}, bus.acc_aud_out, d);
    chk({name, "_clip"}, bus.acc_clip, c);
  endtask

  // Monitor: every transfer edge retires the oldest expected sample.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstb && bus.acc_aud_out_rts === 1'b1 && bus.acc_aud_out_rtr === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_xfer: got %0h expected no transfer", bus.acc_aud_out);
      end else begin
        e = sb_q.pop_front();
        chk("xfer_data", bus.acc_aud_out, e.data);
        chk("xfer_clip", bus.acc_clip, e.clip);
      end
    end
  end

  initial begin
    bus.accumulator_enable   = 1'b0;
    bus.accumulator_load     = 1'b0;
    bus.accumulator_in_left  = 32'h0;
    bus.accumulator_in_right = 32'h0;
    bus.acc_aud_out_rtr      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", bus.acc_aud_out, 32'h0);
    chk("rst_rts", bus.acc_aud_out_rts, 1'b0);
    chk("rst_clip", bus.acc_clip, 2'b00);
    chk("rst_overrun", bus.acc_overrun, 1'b0);
    rstb = 1'b1;

    // Single-term sweep
    cyc(1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_C000, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_out("single", 32'h0001_0000, 2'b00);
    idle(2, 1'b1);

    // Full 512-term sweep saturating both channels
    for (int i = 0; i < 512; i++) cyc(1'b1, i == 0, 32'h3FFF_0001, 32'hC000_0000, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_out("full512", 32'h7FFF_8000, 2'b11);
    idle(2, 1'b1);

    // Load restart discards earlier terms
    for (int i = 0; i < 3; i++) cyc(1'b1, i == 0, 32'h0001_0000, 32'h0001_0000, 1'b1);
    cyc(1'b1, 1'b1, 32'h0000_8000, 32'h0000_8000, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_out("restart", 32'h0001_0001, 2'b00);
    idle(2, 1'b1);

    // Transfer of sweep 1 coincides with completion of sweep 2
    cyc(1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_C000, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 1'b1, 32'h0000_8000, 32'h0000_8000, 1'b0);
    cyc(1'b1, 1'b0, 32'h0000_8000, 32'h0000_8000, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_out("simul", 32'h0002_0002, 2'b00);
    chk("simul_rts", bus.acc_aud_out_rts, 1'b1);
    chk("simul_overrun", bus.acc_overrun, 1'b0);
    idle(2, 1'b1);

    // Backpressure across a second finished sweep
    cyc(1'b1, 1'b1, 32'h0000_4000, 32'hFFFF_C000, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    idle(1, 1'b0);
    cyc(1'b1, 1'b1, 32'h0040_0000, 32'h0040_0000, 1'b0);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_out("held", 32'h0001_0000, 2'b00);
    chk("bp_overrun", bus.acc_overrun, 1'b1);
    idle(1, 1'b1);
    chk("bp_rts_low", bus.acc_aud_out_rts, 1'b0);
    idle(2, 1'b1);

    // Random sweeps, gaps, stray loads and backpressure
    for (int s = 0; s < 60; s++) begin
      int len, gap;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++)
        cyc(1'b1, (i == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0),
            rnd_prod(), rnd_prod(), $urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        cyc(1'b0, $urandom_range(0, 1) == 1, rnd_prod(), rnd_prod(), $urandom_range(0, 3) != 0);
    end
    idle(4, 1'b1);

    // Reset mid-sweep
    for (int i = 0; i < 100; i++) cyc(1'b1, i == 0, 32'h0010_0000, 32'h0010_0000, 1'b1);
    #2;
    rstb = 1'b0;
    model_reset();
    sb_q.delete();
    #1;
    chk("midrst_data", bus.acc_aud_out, 32'h0);
    chk("midrst_rts", bus.acc_aud_out_rts, 1'b0);
    chk("midrst_clip", bus.acc_clip, 2'b00);
    chk("midrst_overrun", bus.acc_overrun, 1'b0);
    bus.accumulator_enable = 1'b0;
    bus.accumulator_load   = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    cyc(1'b1, 1'b1, 32'h0000_8000, 32'h0000_0000, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_out("post_rst", 32'h0001_0000, 2'b00);
    idle(3, 1'b1);

    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
